// File: rtl/pmu_evcond_pkg.sv
// Shared types and field layout for the PMU event conditioner.
// The channel config word packs select, detection mode, prescale and enable
// into bits [14:0]; everything above bit 14 reads back as zero.
package pmu_evcond_pkg;

  // Detection mode applied to the selected raw line
  typedef enum logic [1:0] {
    EV_LEVEL = 2'b00,
    EV_RISE  = 2'b01,
    EV_FALL  = 2'b10,
    EV_BOTH  = 2'b11
  } ev_mode_e;

  // Field layout inside the config word
  localparam int SEL_LSB   = 0;
  localparam int SEL_W     = 8;
  localparam int MODE_LSB  = 8;
  localparam int MODE_W    = 2;
  localparam int PRESC_LSB = 10;
  localparam int PRESC_W   = 4;
  localparam int EN_BIT    = 14;
  localparam int CFG_W     = 15;

  // Stored channel configuration, MSB first so it maps 1:1 onto bits [14:0]
  typedef struct packed {
    logic                en;
    logic [PRESC_W-1:0]  presc;
    ev_mode_e            mode;
    logic [SEL_W-1:0]    sel;
  } evcond_cfg_t;

  // Unpack the meaningful low bits of a written word into the config struct
  function automatic evcond_cfg_t cfg_unpack(input logic [CFG_W-1:0] w);
    evcond_cfg_t c;
    c.sel   = w[SEL_LSB +: SEL_W];
    c.mode  = ev_mode_e'(w[MODE_LSB +: MODE_W]);
    c.presc = w[PRESC_LSB +: PRESC_W];
    c.en    = w[EN_BIT];
    return c;
  endfunction

  // Qualifier: turn the current and previous sample into an event bit
  function automatic logic ev_qualify(input ev_mode_e mode, input logic cur,
                                      input logic prev);
    logic q;
    case (mode)
      EV_LEVEL: q = cur;
      EV_RISE:  q = cur & ~prev;
      EV_FALL:  q = ~cur & prev;
      EV_BOTH:  q = cur ^ prev;
      default:  q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/pmu_evcond_channel.sv
// One conditioned output channel: config register, edge/level qualifier,
// 4-bit prescaler and the registered event output.
// A config write always wins over a same-cycle event and restarts the count.
module pmu_evcond_channel
  import pmu_evcond_pkg::*;
#(
  parameter int N_IN = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_IN-1:0]  in_q_i,
  input  logic [N_IN-1:0]  in_prev_i,
  input  logic             we_i,
  input  logic [CFG_W-1:0] wdata_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             event_o
);

  // Only the low $clog2(N_IN) select bits address the input vector
  localparam int IDX_W = $clog2(N_IN);

  evcond_cfg_t          cfg_q, cfg_d;
  logic [PRESC_W-1:0]   cnt_q, cnt_d;
  logic                 ev_q, ev_d;
  logic [IDX_W-1:0]     idx;
  logic                 cur, prev, qual;

  assign idx = cfg_q.sel[IDX_W-1:0];

  // Pick the selected line; an index past the last input never qualifies
  always_comb begin
    cur  = 1'b0;
    prev = 1'b0;
    if (32'(idx) < N_IN) begin
      cur  = in_q_i[idx];
      prev = in_prev_i[idx];
    end
  end

  assign qual = ev_qualify(cfg_q.mode, cur, prev);

  // Next-state: write, disable, prescaled emit, or hold
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    ev_d  = 1'b0;
    if (we_i) begin
      cfg_d = cfg_unpack(wdata_i);
      cnt_d = '0;
    end else if (!cfg_q.en) begin
      cnt_d = '0;
    end else if (qual) begin
      if (cnt_q == cfg_q.presc) begin
        ev_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_q <= '0;
      cnt_q <= '0;
      ev_q  <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ev_q  <= ev_d;
    end
  end

  assign cfg_o   = cfg_q;
  assign event_o = ev_q;

endmodule

// File: rtl/pmu_event_conditioner.sv
// PMU event conditioner top: input sampling stage (optionally preceded by a
// 2-flop synchronizer when PMU_EVCOND_SYNC_EN is defined), one conditioning
// channel per PMU counter, and the combinational config readback mux.
module pmu_event_conditioner
  import pmu_evcond_pkg::*;
#(
  parameter int N_IN      = 32,
  parameter int N_OUT     = 9,
  parameter int REG_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_IN-1:0]          raw_events_i,
  input  logic                     cfg_we_i,
  input  logic [$clog2(N_OUT)-1:0] cfg_idx_i,
  input  logic [REG_WIDTH-1:0]     cfg_wdata_i,
  output logic [REG_WIDTH-1:0]     cfg_rdata_o,
  output logic [N_OUT-1:0]         events_o
);

  localparam int IDX_W = $clog2(N_OUT);

  logic [N_IN-1:0]  in_d;
  logic [N_IN-1:0]  in_q;
  logic [N_IN-1:0]  in_prev_q;
  logic [CFG_W-1:0] ch_cfg [N_OUT];

`ifdef PMU_EVCOND_SYNC_EN
  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;

  // Two-flop synchronizer for raw lines coming from other clock domains
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_events_i;
      sync2_q <= sync1_q;
    end
  end

  assign in_d = sync2_q;
`else
  assign in_d = raw_events_i;
`endif

  // Sample stage: current and previous value feed every channel's qualifier
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_q      <= '0;
      in_prev_q <= '0;
    end else begin
      in_q      <= in_d;
      in_prev_q <= in_q;
    end
  end

  // Bits above the config field are don't-care on write
  generate
    if (REG_WIDTH > CFG_W) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^cfg_wdata_i[REG_WIDTH-1:CFG_W];
    end
  endgenerate

  for (genvar g = 0; g < N_OUT; g++) begin : g_ch
    pmu_evcond_channel #(
      .N_IN (N_IN)
    ) u_ch (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .in_q_i    (in_q),
      .in_prev_i (in_prev_q),
      .we_i      (cfg_we_i && (cfg_idx_i == IDX_W'(g))),
      .wdata_i   (cfg_wdata_i[CFG_W-1:0]),
      .cfg_o     (ch_cfg[g]),
      .event_o   (events_o[g])
    );
  end

  // Readback of the addressed channel; out-of-range index reads zero
  always_comb begin
    cfg_rdata_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (cfg_idx_i == IDX_W'(i)) begin
        cfg_rdata_o = REG_WIDTH'(ch_cfg[i]);
      end
    end
  end

endmodule

// File: tb/tb_pmu_event_conditioner.sv
// Self-checking bench for pmu_event_conditioner: directed scenarios plus
// randomized traffic, all compared every cycle against a history-based model.
module tb_pmu_event_conditioner;

  localparam int N_IN  = 32;
  localparam int N_OUT = 9;
`ifdef PMU_EVCOND_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] raw;
  logic        we;
  logic [3:0]  idx;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic [8:0]  ev;

  always #5 clk = ~clk;

  pmu_event_conditioner #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .REG_WIDTH (32)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .raw_events_i (raw),
    .cfg_we_i     (we),
    .cfg_idx_i    (idx),
    .cfg_wdata_i  (wd),
    .cfg_rdata_o  (rdata),
    .events_o     (ev)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sampled raw history plus per-channel config and event count
  logic [31:0] hist[$];
  logic [14:0] m_cfg[N_OUT];
  int          m_cnt[N_OUT];
  logic [8:0]  m_ev;
  int          pulses[N_OUT];

  function automatic logic hist_bit(input int k, input int b);
    if (k < 0) return 1'b0;
    return hist[k][b];
  endfunction

  function automatic logic [31:0] make_cfg(input int sel, input int mode, input int presc,
                                           input int en);
    return (32'(en) << 14) | (32'(presc & 15) << 10) | (32'(mode & 3) << 8) | 32'(sel & 255);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [3:0] i);
    if (int'(i) < N_OUT) return {17'b0, m_cfg[i]};
    return 32'b0;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int c = 0; c < N_OUT; c++) begin
      m_cfg[c] = '0;
      m_cnt[c] = 0;
    end
    m_ev = '0;
  endtask

  task automatic clear_pulses();
    for (int c = 0; c < N_OUT; c++) pulses[c] = 0;
  endtask

  // One clock edge as the model sees it
  task automatic model_edge(input logic [31:0] r, input logic w, input logic [3:0] wi,
                            input logic [31:0] wdat);
    int  n, sel, mode, presc;
    logic cur, prev, q, en;
    hist.push_back(r);
    n = hist.size();
    for (int c = 0; c < N_OUT; c++) begin
      m_ev[c] = 1'b0;
      if (w && int'(wi) == c) begin
        m_cfg[c] = wdat[14:0];
        m_cnt[c] = 0;
      end else begin
        en    = m_cfg[c][14];
        sel   = int'(m_cfg[c][7:0]) % N_IN;
        mode  = int'(m_cfg[c][9:8]);
        presc = int'(m_cfg[c][13:10]);
        cur   = hist_bit(n - 1 - D, sel);
        prev  = hist_bit(n - 2 - D, sel);
        case (mode)
          0:       q = cur;
          1:       q = cur && !prev;
          2:       q = !cur && prev;
          default: q = (cur != prev);
        endcase
        if (!en) begin
          m_cnt[c] = 0;
        end else if (q) begin
          m_cnt[c]++;
          if (m_cnt[c] == presc + 1) begin
            m_ev[c]  = 1'b1;
            m_cnt[c] = 0;
          end
        end
      end
    end
  endtask

  // Drive inputs (called just after an edge), take one edge, compare
  task automatic step(input logic [31:0] r, input logic w, input logic [3:0] wi,
                      input logic [31:0] wdat);
    raw = r; we = w; idx = wi; wd = wdat;
    @(posedge clk);
    model_edge(r, w, wi, wdat);
    #1;
    check("events", {23'b0, ev}, {23'b0, m_ev});
    check("rdata", rdata, exp_rdata(wi));
    for (int c = 0; c < N_OUT; c++) pulses[c] += int'(ev[c]);
  endtask

  task automatic idle(input int n, input logic [31:0] r);
    for (int k = 0; k < n; k++) step(r, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_async_events", {23'b0, ev}, 32'd0);
    model_clear();
    we = 1'b0; raw = '0; idx = 4'd0;
    @(posedge clk);
    #1;
    check("rst_hold_events", {23'b0, ev}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] w4;
    rstn = 1'b0; raw = '0; we = 1'b0; idx = '0; wd = '0;
    clear_pulses();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_events", {23'b0, ev}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rstn = 1'b1;

    // All channels disabled: no output for an all-ones input
    idle(10, 32'hFFFF_FFFF);
    check("disabled_pulses", 32'(pulses[0] + pulses[4] + pulses[8]), 32'd0);
    idle(6, 32'd0);

    // Ch0 level mode on raw[3], 5 high cycles -> 5 output cycles
    step(32'd0, 1'b1, 4'd0, make_cfg(3, 0, 0, 1));
    clear_pulses();
    idle(5, 32'h8);
    idle(6, 32'd0);
    check("ch0_level_pulses", 32'(pulses[0]), 32'd5);

    // Ch1 rising edges on raw[7], prescale 2 -> 2 pulses from 6 edges
    step(32'd0, 1'b1, 4'd1, make_cfg(7, 1, 2, 1));
    clear_pulses();
    for (int k = 0; k < 6; k++) begin
      step(32'h80, 1'b0, 4'd1, 32'd0);
      step(32'h00, 1'b0, 4'd1, 32'd0);
    end
    idle(6, 32'd0);
    check("ch1_rise_pulses", 32'(pulses[1]), 32'd2);

    // Ch2 both-edge then fall mode on raw[20]
    step(32'd0, 1'b1, 4'd2, make_cfg(20, 3, 0, 1));
    clear_pulses();
    idle(4, 32'h0010_0000);
    idle(6, 32'd0);
    check("ch2_both_pulses", 32'(pulses[2]), 32'd2);
    step(32'd0, 1'b1, 4'd2, make_cfg(20, 2, 0, 1));
    clear_pulses();
    idle(4, 32'h0010_0000);
    idle(6, 32'd0);
    check("ch2_fall_pulses", 32'(pulses[2]), 32'd1);

    // Ch4 level, presc 3: rewrite coinciding with a qualified event
    step(32'd0, 1'b1, 4'd4, make_cfg(10, 0, 3, 1));
    clear_pulses();
    for (int k = 0; k < 3; k++) step(32'h400, 1'b0, 4'd4, 32'd0);
    w4 = 32'hFFFF_8000 | make_cfg(10, 0, 3, 1);
    step(32'h400, 1'b1, 4'd4, w4);
    check("ch4_rdata_masked", rdata, make_cfg(10, 0, 3, 1));
    for (int k = 0; k < 4; k++) step(32'h400, 1'b0, 4'd4, 32'd0);
    idle(3, 32'd0);
    check("ch4_presc_pulses", 32'(pulses[4]), 32'd1);
    idle(4, 32'd0);

    // Out-of-range index: write ignored, reads zero
    step(32'd0, 1'b1, 4'd12, 32'hFFFF_FFFF);
    check("idx12_rdata", rdata, 32'd0);
    for (int c = 0; c < N_OUT; c++) step(32'd0, 1'b0, 4'(c), 32'd0);
    step(32'd0, 1'b0, 4'd0, 32'd0);
    check("rb_ch0", rdata, make_cfg(3, 0, 0, 1));

    // Randomized traffic with a mid-stream reset
    for (int c = 0; c < N_OUT; c++)
      step(32'd0, 1'b1, 4'(c), make_cfg($urandom_range(0, 255), $urandom_range(0, 3),
                                        $urandom_range(0, 3), 1));
    rv = $urandom;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        do_reset();
        for (int c = 0; c < N_OUT; c++)
          step(rv, 1'b1, 4'(c), make_cfg($urandom_range(0, 255), $urandom_range(0, 3),
                                         $urandom_range(0, 2), 1));
      end
      rv = rv ^ ($urandom & $urandom);
      if ($urandom_range(0, 15) == 0)
        step(rv, 1'b1, 4'($urandom_range(0, 15)), $urandom);
      else
        step(rv, 1'b0, 4'($urandom_range(0, 15)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
